signal_scheduler: RTL and testbench

SIGNAL_SCHEDULER -- requirements
Module: signal_scheduler

---
 rtl/signal_scheduler.sv | 172 +++++++++++++++++
 tb/tb_signal_scheduler.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/signal_scheduler.sv
// Sequences up to three signal generators: each enabled channel is selected,
// restarted and run for its dwell count, optionally looping over the mask.
module signal_scheduler #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             loop,
    input  logic [2:0]       ch_mask,
    input  logic [CNT_W-1:0] dwell0,
    input  logic [CNT_W-1:0] dwell1,
    input  logic [CNT_W-1:0] dwell2,
    input  logic [2:0]       gen_in,
    output logic [2:0]       gen_en,
    output logic [2:0]       gen_clr,
    output logic             out,
    output logic [1:0]       cur_ch,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEL  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_r, state_s;
    logic [1:0]       ch_r, ch_s;
    logic [2:0]       mask_r;
    logic [CNT_W-1:0] dwell_r, cnt_r, dwell_sel_s;
    logic [2:0]       higher_s;

    function automatic logic [1:0] lowest_bit(input logic [2:0] m);
        logic [1:0] r;
        if (m[0])      r = 2'd0;
        else if (m[1]) r = 2'd1;
        else           r = 2'd2;
        return r;
    endfunction

    // Returns {found, index} of the next set bit strictly above c.
    function automatic logic [2:0] higher_bit(input logic [2:0] m, input logic [1:0] c);
        logic [2:0] r;
        r = 3'b000;
        case (c)
            2'd0: begin
                if (m[1])      r = 3'b101;
                else if (m[2]) r = 3'b110;
                else           r = 3'b000;
            end
            2'd1: begin
                if (m[2]) r = 3'b110;
                else      r = 3'b000;
            end
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] c);
        logic [2:0] r;
        case (c)
            2'd0:    r = 3'b001;
            2'd1:    r = 3'b010;
            2'd2:    r = 3'b100;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    // Dwell of the channel being selected, with zero promoted to one.
    always_comb begin
        dwell_sel_s = {CNT_W{1'b0}};
        case (ch_r)
            2'd0:    dwell_sel_s = dwell0;
            2'd1:    dwell_sel_s = dwell1;
            2'd2:    dwell_sel_s = dwell2;
            default: dwell_sel_s = dwell0;
        endcase
        if (dwell_sel_s == {CNT_W{1'b0}}) begin
            dwell_sel_s = CNT_W'(1);
        end else begin
            dwell_sel_s = dwell_sel_s;
        end
    end

    // Next-state and next-channel decision; stop overrides everything.
    always_comb begin
        state_s  = state_r;
        ch_s     = ch_r;
        higher_s = higher_bit(mask_r, ch_r);
        case (state_r)
            IDLE: begin
                if (start && (ch_mask != 3'b000)) begin
                    state_s = SEL;
                    ch_s    = lowest_bit(ch_mask);
                end else begin
                    state_s = IDLE;
                end
            end
            SEL: state_s = RUN;
            RUN: begin
                if (cnt_r == dwell_r - CNT_W'(1)) begin
                    if (higher_s[2]) begin
                        state_s = SEL;
                        ch_s    = higher_s[1:0];
                    end else if (loop) begin
                        state_s = SEL;
                        ch_s    = lowest_bit(mask_r);
                    end else begin
                        state_s = DONE;
                    end
                end else begin
                    state_s = RUN;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
        if (stop) begin
            state_s = IDLE;
        end else begin
            state_s = state_s;
        end
    end

    // State, datapath registers and outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            ch_r    <= 2'd0;
            mask_r  <= 3'b000;
            dwell_r <= CNT_W'(1);
            cnt_r   <= {CNT_W{1'b0}};
            gen_en  <= 3'b000;
            gen_clr <= 3'b000;
            out     <= 1'b0;
            cur_ch  <= 2'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_r <= state_s;
            ch_r    <= ch_s;
            if (state_r == IDLE && state_s == SEL) begin
                mask_r <= ch_mask;
            end else begin
                mask_r <= mask_r;
            end
            if (state_r == SEL) begin
                dwell_r <= dwell_sel_s;
                cnt_r   <= {CNT_W{1'b0}};
            end else if (state_r == RUN) begin
                dwell_r <= dwell_r;
                cnt_r   <= cnt_r + CNT_W'(1);
            end else begin
                dwell_r <= dwell_r;
                cnt_r   <= {CNT_W{1'b0}};
            end
            gen_en  <= (state_s == RUN) ? onehot(ch_s) : 3'b000;
            gen_clr <= (state_s == SEL) ? onehot(ch_s) : 3'b000;
            out     <= (state_r == RUN && !stop) ? gen_in[ch_r] : 1'b0;
            cur_ch  <= (state_s == SEL || state_s == RUN) ? ch_s : 2'd0;
            busy    <= (state_s == SEL || state_s == RUN);
            done    <= (state_s == DONE);
        end
    end

endmodule

// File: tb/tb_signal_scheduler.sv
// Scoreboard bench for signal_scheduler: stimulus queues cycle-tagged expected
// output vectors, a negedge monitor pops and compares them.
module tb_signal_scheduler;

    logic       clk = 1'b0;
    logic       rst, start, stop, loop;
    logic [2:0] ch_mask, gen_in;
    logic [7:0] dwell0, dwell1, dwell2;
    logic [2:0] gen_en, gen_clr;
    logic       out, busy, done;
    logic [1:0] cur_ch;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int          q_cyc[$];
    logic [10:0] q_vec[$];
    string       q_nm[$];

    signal_scheduler #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .loop(loop),
        .ch_mask(ch_mask), .dwell0(dwell0), .dwell1(dwell1), .dwell2(dwell2),
        .gen_in(gen_in), .gen_en(gen_en), .gen_clr(gen_clr), .out(out),
        .cur_ch(cur_ch), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expect outputs dc cycles after the current one.
    task automatic exp(input int dc, input logic [2:0] en, input logic [2:0] clr,
                       input logic o, input logic [1:0] ch, input logic b,
                       input logic d, input string nm);
        q_cyc.push_back(cyc + dc);
        q_vec.push_back({en, clr, o, ch, b, d});
        q_nm.push_back(nm);
    endtask

    // Monitor: compare every queued expectation due in this cycle.
    always @(negedge clk) begin
        logic [10:0] act;
        act = {gen_en, gen_clr, out, cur_ch, busy, done};
        while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
            int          ec;
            logic [10:0] ev;
            string       en;
            ec = q_cyc.pop_front();
            ev = q_vec.pop_front();
            en = q_nm.pop_front();
            checks = checks + 1;
            if (ec != cyc || act !== ev) begin
                errors = errors + 1;
                $display("FAIL %s cyc=%0d due=%0d actual en/clr/out/ch/busy/done=%b required=%b",
                         en, cyc, ec, act, ev);
            end
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0;
        ch_mask = 3'b000; gen_in = 3'b000;
        dwell0 = 8'd0; dwell1 = 8'd0; dwell2 = 8'd0;
        step(); step();
        exp(1, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0, 1'b0, "reset");
        step();
        rst = 1'b0;
        step();

        // Single pass, mask 101, dwell 2 and 3.
        ch_mask = 3'b101; dwell0 = 8'd2; dwell1 = 8'd7; dwell2 = 8'd3; loop = 1'b0;
        start = 1'b1;
        exp(1, 3'b000, 3'b001, 1'b0, 2'd0, 1'b1, 1'b0, "pass_sel0");
        exp(2, 3'b001, 3'b000, 1'b0, 2'd0, 1'b1, 1'b0, "pass_run0a");
        exp(3, 3'b001, 3'b000, 1'b0, 2'd0, 1'b1, 1'b0, "pass_run0b");
        exp(4, 3'b000, 3'b100, 1'b0, 2'd2, 1'b1, 1'b0, "pass_sel2");
        for (int k = 5; k <= 7; k++) exp(k, 3'b100, 3'b000, 1'b0, 2'd2, 1'b1, 1'b0, "pass_run2");
        exp(8, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0, 1'b1, "pass_done");
        exp(9, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0, 1'b0, "pass_idle");
        step();
        start = 1'b0;
        repeat (9) step();

        // Loop wrap over mask 011, then loop cleared during ch1.
        ch_mask = 3'b011; dwell0 = 8'd1; dwell1 = 8'd1; loop = 1'b1;
        start = 1'b1;
        for (int p = 0; p < 2; p++) begin
            exp(4*p+1, 3'b000, 3'b001, 1'b0, 2'd0, 1'b1, 1'b0, "loop_sel0");
            exp(4*p+2, 3'b001, 3'b000, 1'b0, 2'd0, 1'b1, 1'b0, "loop_run0");
            exp(4*p+3, 3'b000, 3'b010, 1'b0, 2'd1, 1'b1, 1'b0, "loop_sel1");
            exp(4*p+4, 3'b010, 3'b000, 1'b0, 2'd1, 1'b1, 1'b0, "loop_run1");
        end
        exp(9, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0, 1'b1, "loop_done");
        exp(10, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0, 1'b0, "loop_idle");
        step();
        start = 1'b0;
        repeat (7) step();
        loop = 1'b0;
        repeat (4) step();

        // Data path latency on ch1 with gen_in[1] toggling.
        ch_mask = 3'b010; dwell1 = 8'd4;
        start = 1'b1;
        exp(1, 3'b000, 3'b010, 1'b0, 2'd1, 1'b1, 1'b0, "data_sel");
        exp(2, 3'b010, 3'b000, 1'b0, 2'd1, 1'b1, 1'b0, "data_run1");
        exp(3, 3'b010, 3'b000, 1'b0, 2'd1, 1'b1, 1'b0, "data_run2");
        exp(4, 3'b010, 3'b000, 1'b1, 2'd1, 1'b1, 1'b0, "data_run3");
        exp(5, 3'b010, 3'b000, 1'b0, 2'd1, 1'b1, 1'b0, "data_run4");
        exp(6, 3'b000, 3'b000, 1'b1, 2'd0, 1'b0, 1'b1, "data_done");
        exp(7, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0, 1'b0, "data_idle");
        for (int k = 0; k < 8; k++) begin
            gen_in = {1'b1, k[0], 1'b1};
            step();
            start = 1'b0;
        end
        gen_in = 3'b000;

        // Abort in the 2nd RUN cycle of dwell 5.
        ch_mask = 3'b001; dwell0 = 8'd5;
        start = 1'b1;
        exp(1, 3'b000, 3'b001, 1'b0, 2'd0, 1'b1, 1'b0, "abort_sel");
        exp(2, 3'b001, 3'b000, 1'b0, 2'd0, 1'b1, 1'b0, "abort_run1");
        exp(3, 3'b001, 3'b000, 1'b0, 2'd0, 1'b1, 1'b0, "abort_run2");
        exp(4, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0, 1'b0, "abort_idle");
        exp(5, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0, 1'b0, "abort_nodone");
        step();
        start = 1'b0;
        step(); step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        repeat (2) step();
        start = 1'b1; stop = 1'b1;
        exp(1, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0, 1'b0, "startstop_1");
        exp(2, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0, 1'b0, "startstop_2");
        step();
        start = 1'b0; stop = 1'b0;
        repeat (2) step();

        // Reset mid-run, then restart from the lowest set bit.
        ch_mask = 3'b110; dwell1 = 8'd3; dwell2 = 8'd3;
        start = 1'b1;
        exp(1, 3'b000, 3'b010, 1'b0, 2'd1, 1'b1, 1'b0, "rstrun_sel1");
        exp(2, 3'b010, 3'b000, 1'b0, 2'd1, 1'b1, 1'b0, "rstrun_run1");
        exp(3, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0, 1'b0, "rstrun_zero");
        exp(4, 3'b000, 3'b010, 1'b0, 2'd1, 1'b1, 1'b0, "restart_sel1");
        for (int k = 5; k <= 7; k++) exp(k, 3'b010, 3'b000, 1'b0, 2'd1, 1'b1, 1'b0, "restart_run1");
        exp(8, 3'b000, 3'b100, 1'b0, 2'd2, 1'b1, 1'b0, "restart_sel2");
        for (int k = 9; k <= 11; k++) exp(k, 3'b100, 3'b000, 1'b0, 2'd2, 1'b1, 1'b0, "restart_run2");
        exp(12, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0, 1'b1, "restart_done");
        step();
        start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (10) step();

        // Empty mask ignores start.
        ch_mask = 3'b000;
        start = 1'b1;
        exp(1, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0, 1'b0, "mask0_1");
        exp(2, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0, 1'b0, "mask0_2");
        step();
        start = 1'b0;
        repeat (2) step();

        // Dwell 0 behaves as a single RUN cycle.
        ch_mask = 3'b001; dwell0 = 8'd0;
        start = 1'b1;
        exp(1, 3'b000, 3'b001, 1'b0, 2'd0, 1'b1, 1'b0, "dw0_sel");
        exp(2, 3'b001, 3'b000, 1'b0, 2'd0, 1'b1, 1'b0, "dw0_run");
        exp(3, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0, 1'b1, "dw0_done");
        exp(4, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0, 1'b0, "dw0_idle");
        step();
        start = 1'b0;
        repeat (4) step();

        // Dwell 255 on ch2; mask/dwell changes mid-visit must not matter.
        ch_mask = 3'b100; dwell2 = 8'd255;
        start = 1'b1;
        exp(1, 3'b000, 3'b100, 1'b0, 2'd2, 1'b1, 1'b0, "dw255_sel");
        for (int k = 2; k <= 256; k++) exp(k, 3'b100, 3'b000, 1'b0, 2'd2, 1'b1, 1'b0, "dw255_run");
        exp(257, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0, 1'b1, "dw255_done");
        exp(258, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0, 1'b0, "dw255_idle");
        step();
        start = 1'b0;
        repeat (10) step();
        ch_mask = 3'b001; dwell2 = 8'd3;
        repeat (252) step();

        if (q_cyc.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain pending=%0d required=0", q_cyc.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
